// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the flit-stream adder arbiter.
//   N_DEF / NUM_REQ_DEF / MAX_FLITS_DEF : default operand width, requester count, flit limit
//   ID_W_DEF                            : requester index width for the default requester count
//   arb_state_e                         : arbiter state (IDLE, BUSY)
//   rr_first()                          : round-robin pick, first set bit at or after ptr (cyclic)
package adder_pkg;

    localparam int N_DEF         = 15;
    localparam int NUM_REQ_DEF   = 4;
    localparam int MAX_FLITS_DEF = 20;
    localparam int ID_W_DEF      = $clog2(NUM_REQ_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Returns the index of the first set request at or after ptr, wrapping
    // at num; -1 when no request is set. Supports up to 32 requesters.
    function automatic int rr_first(input logic [31:0] req, input int ptr, input int num);
        int k;
        rr_first = -1;
        for (int i = 0; i < 32; i++) begin
            k = ptr + i;
            if (k >= num) k = k - num;
            if (i < num && rr_first < 0 && req[k[4:0]]) rr_first = k;
        end
    endfunction

endpackage

// File: rtl/adder.sv
// adder: the characterized combinational adder; carry out is dropped.
//   input1, input2 : N-bit operands
//   sum            : (input1 + input2) mod 2^N
module adder #(
    parameter int N = 15
) (
    input  logic [N-1:0] input1,
    input  logic [N-1:0] input2,
    output logic [N-1:0] sum
);

    assign sum = input1 + input2;

endmodule

// File: rtl/adder_flit_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority index for this pick
//   idx   : chosen requester (0 when nothing is requested)
//   found : at least one request is set
module rr_pick
    import adder_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    int pick;

    always_comb begin
        pick  = rr_first(32'(req), int'(ptr), NUM_REQ);
        found = (pick >= 0);
        idx   = '0;
        if (found) idx = ID_W'(pick);
    end

endmodule

// File: rtl/adder_flit_arbiter.sv
// adder_flit_arbiter: shares one adder between NUM_REQ flit-stream requesters.
// Packet-granular round robin; the grant is held until the last flit (or the
// MAX_FLITS-th flit) is accepted. Operand registers only load on an accepted
// flit, so the adder inputs are frozen between packets.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_last    : per-requester flit valid and last-of-packet flag
//   req_op1/req_op2       : flattened operands, requester i at [i*N +: N]
//   req_ready             : per-requester accept
//   res_valid/res_ready   : result handshake
//   res_sum/res_id        : sum of the registered operands and its requester
//   res_last              : result closes its packet (normal or forced)
//   err_trunc             : one-cycle pulse with a result that was force-released
module adder_flit_arbiter
    import adder_pkg::*;
#(
    parameter  int N         = N_DEF,
    parameter  int NUM_REQ   = NUM_REQ_DEF,
    parameter  int MAX_FLITS = MAX_FLITS_DEF,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_FLITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [NUM_REQ*N-1:0] req_op1,
    input  logic [NUM_REQ*N-1:0] req_op2,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [N-1:0]         res_sum,
    output logic [ID_W-1:0]      res_id,
    output logic                 res_last,
    output logic                 err_trunc
);

    arb_state_e         state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    grant_id_q;
    logic [ID_W-1:0]    res_id_q;
    logic [CNT_W-1:0]   flit_cnt_q;
    logic [N-1:0]       op1_q;
    logic [N-1:0]       op2_q;
    logic               res_valid_q;
    logic               res_last_q;
    logic               err_trunc_q;

    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_found;
    logic               stall;
    logic               accept;
    logic               sel_last;
    logic               cnt_max;
    logic               pkt_end;
    logic [N-1:0]       sel_op1;
    logic [N-1:0]       sel_op2;
    logic [N-1:0]       sum;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    adder #(.N(N)) u_adder (
        .input1 (op1_q),
        .input2 (op2_q),
        .sum    (sum)
    );

    always_comb begin
        grant_oh             = '0;
        grant_oh[grant_id_q] = 1'b1;
    end

    // A held result blocks new flits; draining and accepting in one cycle is allowed.
    assign stall     = res_valid_q & ~res_ready;
    assign req_ready = (state_q == BUSY && !stall) ? grant_oh : '0;
    assign accept    = |(req_valid & req_ready);

    assign sel_last  = req_last[grant_id_q];
    assign sel_op1   = req_op1[int'(grant_id_q)*N +: N];
    assign sel_op2   = req_op2[int'(grant_id_q)*N +: N];
    assign cnt_max   = (flit_cnt_q == CNT_W'(MAX_FLITS - 1));
    assign pkt_end   = sel_last | cnt_max;
    assign rr_ptr_d  = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            flit_cnt_q  <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_last_q  <= 1'b0;
            err_trunc_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_id_q <= pick_idx;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        op1_q <= sel_op1;
                        op2_q <= sel_op2;
                        if (pkt_end) begin
                            state_q    <= IDLE;
                            rr_ptr_q   <= rr_ptr_d;
                            flit_cnt_q <= '0;
                        end else begin
                            flit_cnt_q <= flit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (accept) begin
                res_valid_q <= 1'b1;
                res_id_q    <= grant_id_q;
                res_last_q  <= pkt_end;
            end else if (res_ready) begin
                res_valid_q <= 1'b0;
            end

            // Only a release caused by the flit limit is a truncation.
            err_trunc_q <= accept & cnt_max & ~sel_last;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = sum;
    assign res_id    = res_id_q;
    assign res_last  = res_last_q;
    assign err_trunc = err_trunc_q;

endmodule
